mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/riscv_mem_pkg.sv | 35 +++
 rtl/mem_access_unit_load_formatter.sv | 39 +++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory access unit: FSM state encoding,
// FUNC3 access-size codes and the byte-enable width.
package riscv_mem_pkg;

  localparam int BYTEEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int F3_UNSIGNED_BIT = 2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Unused encodings (011, 110, 111) fall through to word accesses.
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: picks the byte/half lane addressed by
// offset out of the read word and sign- or zero-extends it by FUNC3.
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] read_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction from the aligned read word.
  always_comb begin
    byte_sel = read_word[7:0];
    case (offset)
      2'd1:    byte_sel = read_word[15:8];
      2'd2:    byte_sel = read_word[23:16];
      2'd3:    byte_sel = read_word[31:24];
      default: byte_sel = read_word[7:0];
    endcase
    half_sel = offset[1] ? read_word[31:16] : read_word[15:0];
  end

  // Extension according to access size and signedness.
  always_comb begin
    result = read_word;
    case (access_size(func3))
      SZ_BYTE: result = func3[F3_UNSIGNED_BIT] ? {24'h0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: result = func3[F3_UNSIGNED_BIT] ? {16'h0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
      default: result = read_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit between the EX/MEM register and a word-wide data
// memory with a busywait handshake. Stalls the pipeline while an access
// is in flight and formats load results.
// Optional feature: define MEM_MISALIGN_TRAP_EN to turn misaligned half/word
// requests into a one-cycle MISALIGN fault with no memory access; without it
// the offending low address bits are ignored.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a strobe; captures the request on the edge
// ST_ACCESS | memory strobes driven from registers until busywait drops
// ST_DONE   | one-cycle release; EX/MEM still shows the finished request
module mem_access_unit
  import riscv_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         aluud,
  input  logic [31:0]         data2,
  input  logic [2:0]          func3,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_writedata,
  output logic [BYTEEN_W-1:0] dmem_byteen,
  input  logic [31:0]         dmem_readdata,
  input  logic                dmem_busywait,
  output logic                busywait,
  output logic [31:0]         load_data,
  output logic                misalign
);

  state_t              state;
  logic                rd_q, wr_q, misalign_q;
  logic [1:0]          off_q;
  logic [2:0]          func3_q;
  logic [31:0]         addr_q, wdata_q;
  logic [BYTEEN_W-1:0] byteen_q;

  logic                req, fault_trap;
  logic [1:0]          size, off_nxt;
  logic [31:0]         wdata_nxt, load_fmt;
  logic [BYTEEN_W-1:0] byteen_nxt;

  assign req  = mem_read | mem_write;
  assign size = access_size(func3);

`ifdef MEM_MISALIGN_TRAP_EN
  assign fault_trap = ((size == SZ_HALF) && aluud[0]) ||
                      ((size == SZ_WORD) && (aluud[1:0] != 2'b00));
`else
  assign fault_trap = 1'b0;
`endif

  // Store lane replication, byte enables and the lane offset kept for loads;
  // misaligned low bits are dropped so half uses addr[1] and word uses lane 0.
  always_comb begin
    off_nxt    = 2'b00;
    wdata_nxt  = data2;
    byteen_nxt = '1;
    case (size)
      SZ_BYTE: begin
        off_nxt    = aluud[1:0];
        wdata_nxt  = {4{data2[7:0]}};
        byteen_nxt = BYTEEN_W'(1) << aluud[1:0];
      end
      SZ_HALF: begin
        off_nxt    = {aluud[1], 1'b0};
        wdata_nxt  = {2{data2[15:0]}};
        byteen_nxt = aluud[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  load_formatter u_load_formatter (
    .read_word (dmem_readdata),
    .offset    (off_q),
    .func3     (func3_q),
    .result    (load_fmt)
  );

  // Request capture, access sequencing and load result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      misalign_q <= 1'b0;
      off_q      <= 2'b00;
      func3_q    <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= '0;
      load_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            rd_q     <= mem_read;
            wr_q     <= mem_write & ~mem_read;
            addr_q   <= {aluud[31:2], 2'b00};
            off_q    <= off_nxt;
            func3_q  <= func3;
            wdata_q  <= wdata_nxt;
            byteen_q <= byteen_nxt;
            if (fault_trap) begin
              state      <= ST_DONE;
              misalign_q <= 1'b1;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!dmem_busywait) begin
            state <= ST_DONE;
            if (rd_q) load_data <= load_fmt;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          misalign_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes only while in ACCESS so a reset or completion drops them at once.
  assign dmem_read      = (state == ST_ACCESS) && rd_q;
  assign dmem_write     = (state == ST_ACCESS) && wr_q;
  assign dmem_addr      = addr_q;
  assign dmem_writedata = wdata_q;
  assign dmem_byteen    = byteen_q;
  assign misalign       = misalign_q;

  // Stall is combinational on the request so the pipeline freezes the same
  // cycle; gated by reset so a held strobe cannot stall during reset.
  assign busywait = reset && (((state == ST_IDLE) && req) || (state == ST_ACCESS));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model of the
// expected per-cycle outputs plus literal expectations for the key vectors.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] aluud = '0, data2 = '0;
  logic [2:0]  func3 = '0;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_writedata;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_readdata = '0;
  logic        dmem_busywait = 1'b0;
  logic        busywait;
  logic [31:0] load_data;
  logic        misalign;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] rw;
    int          nb;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic        chk_en = 1'b0;
  logic        exp_bw = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0, exp_load = '0;
  logic [3:0]  exp_be = '0;

  int          bwh, fl, mc;
  logic [31:0] ca, cw;
  logic [3:0]  cb;
  vec_t        vt[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .reset          (rst_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .aluud          (aluud),
    .data2          (data2),
    .func3          (func3),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_addr      (dmem_addr),
    .dmem_writedata (dmem_writedata),
    .dmem_byteen    (dmem_byteen),
    .dmem_readdata  (dmem_readdata),
    .dmem_busywait  (dmem_busywait),
    .busywait       (busywait),
    .load_data      (load_data),
    .misalign       (misalign)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ---- model ----
  function automatic int m_size(input logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int m_off(input logic [31:0] a, input int sz);
    int o;
    o = int'(a % 4);
    if (sz == 1) return o;
    if (sz == 2) return (o / 2) * 2;
    return 0;
  endfunction

  function automatic logic m_fault(input logic [31:0] a, input logic [2:0] f);
    int sz;
    sz = m_size(f);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
    int sz;
    logic [31:0] s;
    sz = m_size(f);
    s  = w >> (8 * m_off(a, sz));
    if (sz == 1) return f[2] ? {24'h0, s[7:0]} : 32'($signed(s[7:0]));
    if (sz == 2) return f[2] ? {16'h0, s[15:0]} : 32'($signed(s[15:0]));
    return w;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r;
    int sz;
    sz = m_size(f);
    r  = '0;
    for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = d[8*(lane % sz) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f);
    logic [3:0] r;
    int sz, off;
    sz  = m_size(f);
    off = m_off(a, sz);
    for (int lane = 0; lane < 4; lane++) r[lane] = (lane >= off) && (lane < off + sz);
    return r;
  endfunction

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] f,
                              input logic [31:0] rw, input int nb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.f = f; v.rw = rw; v.nb = nb;
    return v;
  endfunction

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (chk_en) begin
      check("busywait",   32'(busywait),   32'(exp_bw));
      check("dmem_read",  32'(dmem_read),  32'(exp_rd));
      check("dmem_write", 32'(dmem_write), 32'(exp_wr));
      check("misalign",   32'(misalign),   32'(exp_mis));
      check("load_data",  load_data,       exp_load);
      if (exp_rd || exp_wr) check("dmem_addr", dmem_addr, exp_addr);
      if (exp_wr) begin
        check("dmem_writedata", dmem_writedata, exp_wd);
        check("dmem_byteen",    32'(dmem_byteen), 32'(exp_be));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; dmem_busywait = 1'b0;
      exp_bw = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_mis = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_req(input vec_t v, output int bw_high, output int first_low,
                        output int mis_cnt, output logic [31:0] cap_addr,
                        output logic [31:0] cap_wd, output logic [3:0] cap_be);
    logic trap;
    int   idx;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = m_fault(v.a, v.f);
`endif
    bw_high = 0; first_low = -1; mis_cnt = 0; idx = 0;
    cap_addr = '0; cap_wd = '0; cap_be = '0;

    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; aluud = v.a; data2 = v.d; func3 = v.f;
    dmem_readdata = v.rw; dmem_busywait = 1'b0;
    exp_bw = 1'b1; exp_rd = 1'b0; exp_wr = 1'b0; exp_mis = 1'b0;
    @(negedge clk);
    if (busywait) bw_high++; else if (first_low < 0) first_low = idx;
    if (misalign) mis_cnt++;
    idx++;

    if (!trap) begin
      for (int k = 0; k <= v.nb; k++) begin
        @(posedge clk); #1;
        dmem_busywait = (k < v.nb);
        exp_rd = v.rd; exp_wr = v.wr & ~v.rd;
        exp_addr = {v.a[31:2], 2'b00};
        exp_wd = m_wdata(v.d, v.f);
        exp_be = m_be(v.a, v.f);
        @(negedge clk);
        if (busywait) bw_high++; else if (first_low < 0) first_low = idx;
        if (misalign) mis_cnt++;
        if (k == 0) begin
          cap_addr = dmem_addr; cap_wd = dmem_writedata; cap_be = dmem_byteen;
        end
        idx++;
      end
    end

    @(posedge clk); #1;
    dmem_busywait = 1'b0;
    exp_bw = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_mis = trap;
    if (v.rd && !trap) exp_load = m_load(v.rw, v.a, v.f);
    @(negedge clk);
    if (busywait) bw_high++; else if (first_low < 0) first_low = idx;
    if (misalign) mis_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time_limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values, with a strobe held to show the stall is suppressed.
    mem_read = 1'b1; func3 = 3'b010;
    #12;
    check("rst_busywait",   32'(busywait),   32'h0);
    check("rst_dmem_read",  32'(dmem_read),  32'h0);
    check("rst_dmem_write", 32'(dmem_write), 32'h0);
    check("rst_dmem_addr",  dmem_addr,       32'h0);
    check("rst_wdata",      dmem_writedata,  32'h0);
    check("rst_byteen",     32'(dmem_byteen), 32'h0);
    check("rst_load_data",  load_data,       32'h0);
    check("rst_misalign",   32'(misalign),   32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_load = '0;
    chk_en = 1'b1;
    idle(2);

    // LB 0x103 -> sign-extended top byte, two stall cycles.
    do_req(mk(1, 0, 32'h103, 32'h0, 3'b000, 32'h80FF_FFFF, 0), bwh, fl, mc, ca, cw, cb);
    check("lb_load_literal", load_data, 32'hFFFF_FF80);
    check("lb_busy_cycles", 32'(bwh), 32'd2);
    check("lb_release_cycle", 32'(fl), 32'd2);

    // LHU 0x001: trap when enabled, otherwise lane 0 half.
    do_req(mk(1, 0, 32'h001, 32'h0, 3'b101, 32'hAAAA_5555, 0), bwh, fl, mc, ca, cw, cb);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_load_unchanged", load_data, 32'hFFFF_FF80);
    check("mis_pulse_cycles", 32'(mc), 32'd1);
    check("mis_busy_cycles", 32'(bwh), 32'd1);
`else
    check("mis_ignored_load", load_data, 32'h0000_5555);
    check("mis_pulse_cycles", 32'(mc), 32'd0);
    check("mis_release_cycle", 32'(fl), 32'd2);
`endif

    // SH 0x202 -> upper half lanes.
    do_req(mk(0, 1, 32'h202, 32'h0000_BEEF, 3'b001, 32'h0, 0), bwh, fl, mc, ca, cw, cb);
    check("sh_wdata_literal", cw, 32'hBEEF_BEEF);
    check("sh_byteen_literal", 32'(cb), 32'h0000_000C);
    check("sh_addr_literal", ca, 32'h0000_0200);

    // LW with three busy cycles.
    do_req(mk(1, 0, 32'h040, 32'h0, 3'b010, 32'h0102_0304, 3), bwh, fl, mc, ca, cw, cb);
    check("lw_busy_cycles", 32'(bwh), 32'd5);
    check("lw_release_cycle", 32'(fl), 32'd5);
    check("lw_load_literal", load_data, 32'h0102_0304);

    // LH 0x102 pins signed half extraction.
    do_req(mk(1, 0, 32'h102, 32'h0, 3'b001, 32'h8001_7FFF, 1), bwh, fl, mc, ca, cw, cb);
    check("lh_load_literal", load_data, 32'hFFFF_8001);

    // Directed table checked cycle by cycle against the model.
    vt.push_back(mk(1, 0, 32'h100, 32'h0,         3'b101, 32'h1234_ABCD, 0));
    vt.push_back(mk(1, 0, 32'h101, 32'h0,         3'b100, 32'h1122_33F4, 2));
    vt.push_back(mk(1, 0, 32'h100, 32'h0,         3'b000, 32'h0000_00FF, 0));
    vt.push_back(mk(1, 0, 32'h3FC, 32'h0,         3'b010, 32'hDEAD_BEEF, 1));
    vt.push_back(mk(0, 1, 32'h201, 32'h0000_00A5, 3'b000, 32'h0,         0));
    vt.push_back(mk(0, 1, 32'h203, 32'h1122_3344, 3'b000, 32'h0,         1));
    vt.push_back(mk(0, 1, 32'h204, 32'h0000_CAFE, 3'b001, 32'h0,         0));
    vt.push_back(mk(0, 1, 32'h208, 32'h1234_5678, 3'b010, 32'h0,         2));
    vt.push_back(mk(1, 1, 32'h20C, 32'h5555_5555, 3'b010, 32'h0BAD_F00D, 0));
    vt.push_back(mk(1, 0, 32'h210, 32'h0,         3'b011, 32'h55AA_55AA, 0));
    vt.push_back(mk(0, 1, 32'h214, 32'h8765_4321, 3'b110, 32'h0,         1));
    vt.push_back(mk(1, 0, 32'h218, 32'h0,         3'b111, 32'hC0DE_0001, 0));
    vt.push_back(mk(0, 1, 32'h206, 32'hFACE_0001, 3'b010, 32'h0,         0));
    vt.push_back(mk(1, 0, 32'h10A, 32'h0,         3'b000, 32'h007F_0000, 0));
    foreach (vt[i]) do_req(vt[i], bwh, fl, mc, ca, cw, cb);
    idle(1);

    // Back-to-back SW then LBU.
    do_req(mk(0, 1, 32'h300, 32'hFEED_FACE, 3'b010, 32'h0, 0), bwh, fl, mc, ca, cw, cb);
    check("b2b_sw_wdata", cw, 32'hFEED_FACE);
    do_req(mk(1, 0, 32'h301, 32'h0, 3'b100, 32'h0000_AB00, 0), bwh, fl, mc, ca, cw, cb);
    check("b2b_lbu_load", load_data, 32'h0000_00AB);
    check("b2b_lbu_release", 32'(fl), 32'd2);

    // Reset in the middle of a stalled LW.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; aluud = 32'h80; func3 = 3'b010;
    dmem_readdata = 32'h1111_2222; dmem_busywait = 1'b1;
    exp_bw = 1'b1; exp_rd = 1'b0; exp_wr = 1'b0; exp_mis = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_rd = 1'b1; exp_addr = 32'h80;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid_dmem_read", 32'(dmem_read), 32'h0);
    check("rstmid_busywait",  32'(busywait),  32'h0);
    check("rstmid_load_data", load_data,      32'h0);
    @(negedge clk);
    mem_read = 1'b0; dmem_busywait = 1'b0;
    rst_n = 1'b1;
    exp_load = '0; exp_bw = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_mis = 1'b0;
    chk_en = 1'b1;
    idle(3);

    // Normal latency after release confirms the unit is back in IDLE.
    do_req(mk(1, 0, 32'h102, 32'h0, 3'b100, 32'h0077_0000, 0), bwh, fl, mc, ca, cw, cb);
    check("post_rst_load", load_data, 32'h0000_0077);
    check("post_rst_release", 32'(fl), 32'd2);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
